// File: rtl/cmp_search.sv
// ---------------------------------------------------------------------------
// cmp_search
//
// Sequential controller for an external one-hot lt/gt/eq magnitude comparator.
// It drives a trial operand (o_guess) plus an enable (o_cmp_en), reads back
// the comparator flags and binary-searches for the value on the comparator's
// other operand. An unknown WIDTH-bit value is recovered in at most WIDTH+1
// compare cycles.
//
// Ports
//   clk          rising-edge clock
//   rst          asynchronous, active-high reset
//   i_start      one-cycle search request (ignored unless in IDLE)
//   i_cmp_lt     comparator flag: guess <  target
//   i_cmp_gt     comparator flag: guess >  target
//   i_cmp_eq     comparator flag: guess == target
//   o_guess      trial operand to the comparator (registered)
//   o_cmp_en     comparator enable, high only in CMP
//   o_busy       high while in CMP
//   o_done       one-cycle pulse when a search ends
//   o_found      target located (valid with o_done, held until next start)
//   o_err        illegal or inconsistent flags (valid with o_done, held)
//   o_result     located value, valid when o_found=1 (held until next start)
//   o_state      current FSM state for observation
//
// Handshake: a request is accepted on any rising edge where i_start=1 and the
// FSM is in IDLE (o_busy=0, o_done=0). Completion is signalled by a one-cycle
// o_done pulse; o_found/o_err/o_result stay stable from that cycle until the
// next accepted request. There is no back-pressure on o_done.
// ---------------------------------------------------------------------------
module cmp_search #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_start,
  input  logic             i_cmp_lt,
  input  logic             i_cmp_gt,
  input  logic             i_cmp_eq,
  output logic [WIDTH-1:0] o_guess,
  output logic             o_cmp_en,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_found,
  output logic             o_err,
  output logic [WIDTH-1:0] o_result,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_n;

  // Bounds carry one extra bit so guess+1 / guess-1 never wrap.
  logic [WIDTH:0]   r_lo;
  logic [WIDTH:0]   r_hi;
  logic [WIDTH:0]   w_lo_n;
  logic [WIDTH:0]   w_hi_n;

  logic [WIDTH-1:0] r_guess;
  logic [WIDTH-1:0] w_guess_n;
  logic             r_found;
  logic             w_found_n;
  logic             r_err;
  logic             w_err_n;
  logic [WIDTH-1:0] r_result;
  logic [WIDTH-1:0] w_result_n;

  logic [WIDTH:0]   w_guess_ext;
  logic [WIDTH:0]   w_lo_inc;
  logic [WIDTH:0]   w_hi_dec;
  logic [WIDTH:0]   w_sum;
  logic [2:0]       w_flags;

  assign w_guess_ext = {1'b0, r_guess};
  assign w_lo_inc    = w_guess_ext + {{WIDTH{1'b0}}, 1'b1};
  assign w_hi_dec    = w_guess_ext - {{WIDTH{1'b0}}, 1'b1};
  assign w_flags     = {i_cmp_lt, i_cmp_gt, i_cmp_eq};

  // lo <= 2^WIDTH and hi <= 2^WIDTH-1, so the sum fits in WIDTH+1 bits.
  assign w_sum       = w_lo_n + w_hi_n;
  assign w_guess_n   = WIDTH'(w_sum >> 1);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= IDLE;
      r_lo     <= '0;
      r_hi     <= '0;
      r_guess  <= '0;
      r_found  <= 1'b0;
      r_err    <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_n;
      r_lo     <= w_lo_n;
      r_hi     <= w_hi_n;
      r_guess  <= w_guess_n;
      r_found  <= w_found_n;
      r_err    <= w_err_n;
      r_result <= w_result_n;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic. The comparator is combinational, so its flags are
  // consumed on the edge that closes each CMP cycle. guess is recomputed from
  // the next bounds every cycle, so it always equals (lo+hi)>>1.
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_n  = r_state;
    w_lo_n     = r_lo;
    w_hi_n     = r_hi;
    w_found_n  = r_found;
    w_err_n    = r_err;
    w_result_n = r_result;

    case (r_state)
      IDLE: begin
        if (i_start) begin
          w_lo_n     = '0;
          w_hi_n     = {1'b0, {WIDTH{1'b1}}};
          w_found_n  = 1'b0;
          w_err_n    = 1'b0;
          w_result_n = '0;
          w_state_n  = CMP;
        end
      end

      CMP: begin
        case (w_flags)
          3'b001: begin
            w_result_n = r_guess;
            w_found_n  = 1'b1;
            w_state_n  = DONE;
          end
          3'b100: begin
            w_lo_n = w_lo_inc;
            if (w_lo_inc > r_hi) begin
              w_err_n   = 1'b1;
              w_state_n = DONE;
            end
          end
          3'b010: begin
            // gt at guess 0 means no smaller value exists: inconsistent.
            if (r_guess == '0) begin
              w_err_n   = 1'b1;
              w_state_n = DONE;
            end else begin
              w_hi_n = w_hi_dec;
              if (r_lo > w_hi_dec) begin
                w_err_n   = 1'b1;
                w_state_n = DONE;
              end
            end
          end
          default: begin
            // No flag or several flags at once.
            w_err_n   = 1'b1;
            w_state_n = DONE;
          end
        endcase
      end

      DONE: begin
        w_state_n = IDLE;
      end

      default: begin
        w_state_n = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign o_guess  = r_guess;
  assign o_cmp_en = (r_state == CMP);
  assign o_busy   = (r_state == CMP);
  assign o_done   = (r_state == DONE);
  assign o_found  = r_found;
  assign o_err    = r_err;
  assign o_result = r_result;
  assign o_state  = r_state;

endmodule

// File: tb/tb_cmp_search.sv
module tb_cmp_search;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic         cmp_lt;
  logic         cmp_gt;
  logic         cmp_eq;
  logic [W-1:0] guess;
  logic         cmp_en;
  logic         busy;
  logic         done;
  logic         found;
  logic         err;
  logic [W-1:0] result;
  logic [1:0]   state;

  logic [W-1:0] target;
  logic         force_both;
  logic         force_gt;

  int n_checks;
  int n_errors;

  cmp_search #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .i_start  (start),
    .i_cmp_lt (cmp_lt),
    .i_cmp_gt (cmp_gt),
    .i_cmp_eq (cmp_eq),
    .o_guess  (guess),
    .o_cmp_en (cmp_en),
    .o_busy   (busy),
    .o_done   (done),
    .o_found  (found),
    .o_err    (err),
    .o_result (result),
    .o_state  (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational comparator model with fault-injection overrides.
  always_comb begin
    cmp_lt = (guess < target);
    cmp_gt = (guess > target);
    cmp_eq = (guess == target);
    if (force_both) begin
      cmp_lt = 1'b1;
      cmp_gt = 1'b1;
      cmp_eq = 1'b0;
    end else if (force_gt) begin
      cmp_lt = 1'b0;
      cmp_gt = 1'b1;
      cmp_eq = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Check outputs of an active CMP cycle.
  task automatic check_cmp(input string tag, input logic [W-1:0] exp_guess);
    check({tag, "_guess"}, 32'(guess), 32'(exp_guess));
    check({tag, "_cmp_en"}, 32'(cmp_en), 32'd1);
    check({tag, "_busy"}, 32'(busy), 32'd1);
    check({tag, "_done"}, 32'(done), 32'd0);
  endtask

  task automatic check_done(input string tag, input logic exp_found, input logic exp_err,
                            input logic [W-1:0] exp_result);
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_cmp_en"}, 32'(cmp_en), 32'd0);
    check({tag, "_found"}, 32'(found), 32'(exp_found));
    check({tag, "_err"}, 32'(err), 32'(exp_err));
    check({tag, "_result"}, 32'(result), 32'(exp_result));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_guess"}, 32'(guess), 32'd0);
    check({tag, "_cmp_en"}, 32'(cmp_en), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_found"}, 32'(found), 32'd0);
    check({tag, "_err"}, 32'(err), 32'd0);
    check({tag, "_result"}, 32'(result), 32'd0);
  endtask

  // Driver: one-cycle start pulse; returns at the negedge after the sampling
  // edge, when the first CMP cycle is visible.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks   = 0;
    n_errors   = 0;
    rst        = 1'b1;
    start      = 1'b0;
    target     = '0;
    force_both = 1'b0;
    force_gt   = 1'b0;

    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("idle");

    // Target 7: hit on the first compare, done two cycles after start.
    target = 4'd7;
    pulse_start();
    check_cmp("t7_c1", 4'd7);
    @(negedge clk);
    check_done("t7", 1'b1, 1'b0, 4'd7);
    @(negedge clk);
    check("t7_idle_done", 32'(done), 32'd0);
    check("t7_held_result", 32'(result), 32'd7);

    // Target 0: 7, 3, 1, 0.
    target = 4'd0;
    pulse_start();
    check_cmp("t0_c1", 4'd7);
    @(negedge clk);
    check_cmp("t0_c2", 4'd3);
    @(negedge clk);
    check_cmp("t0_c3", 4'd1);
    @(negedge clk);
    check_cmp("t0_c4", 4'd0);
    @(negedge clk);
    check_done("t0", 1'b1, 1'b0, 4'd0);
    @(negedge clk);

    // Target 15: 7, 11, 13, 14, 15 (WIDTH+1 compares).
    target = 4'd15;
    pulse_start();
    check_cmp("t15_c1", 4'd7);
    @(negedge clk);
    check_cmp("t15_c2", 4'd11);
    @(negedge clk);
    check_cmp("t15_c3", 4'd13);
    @(negedge clk);
    check_cmp("t15_c4", 4'd14);
    @(negedge clk);
    check_cmp("t15_c5", 4'd15);
    @(negedge clk);
    check_done("t15", 1'b1, 1'b0, 4'd15);
    // Start raised during DONE is ignored; held into IDLE it is accepted.
    target = 4'd7;
    start  = 1'b1;
    @(negedge clk);
    check("t15_busy_after_done", 32'(busy), 32'd0);
    check("t15_no_done_after", 32'(done), 32'd0);
    check("t15_result_held", 32'(result), 32'd15);
    @(negedge clk);
    start = 1'b0;
    check_cmp("b2b_c1", 4'd7);
    check("b2b_result_cleared", 32'(result), 32'd0);
    check("b2b_found_cleared", 32'(found), 32'd0);
    @(negedge clk);
    check_done("b2b", 1'b1, 1'b0, 4'd7);
    @(negedge clk);

    // Illegal flags (lt and gt together) on the second compare.
    target = 4'd5;
    pulse_start();
    check_cmp("both_c1", 4'd7);
    @(negedge clk);
    force_both = 1'b1;
    check_cmp("both_c2", 4'd3);
    @(negedge clk);
    force_both = 1'b0;
    check_done("both", 1'b0, 1'b1, 4'd0);
    @(negedge clk);
    check("both_err_held", 32'(err), 32'd1);

    // gt on every compare: 7, 3, 1, 0 then err at guess 0.
    force_gt = 1'b1;
    pulse_start();
    check("gt_err_cleared", 32'(err), 32'd0);
    check_cmp("gt_c1", 4'd7);
    @(negedge clk);
    check_cmp("gt_c2", 4'd3);
    @(negedge clk);
    check_cmp("gt_c3", 4'd1);
    @(negedge clk);
    check_cmp("gt_c4", 4'd0);
    @(negedge clk);
    check_done("gt", 1'b0, 1'b1, 4'd0);
    force_gt = 1'b0;
    @(negedge clk);

    // Reset during the third compare of a target-15 search.
    target = 4'd15;
    pulse_start();
    check_cmp("rst_c1", 4'd7);
    @(negedge clk);
    check_cmp("rst_c2", 4'd11);
    @(negedge clk);
    check_cmp("rst_c3", 4'd13);
    rst = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    @(negedge clk);
    rst = 1'b0;
    check_reset_outputs("rst_held");
    repeat (3) begin
      @(negedge clk);
      check("rst_no_done", 32'(done), 32'd0);
    end
    pulse_start();
    check_cmp("rst2_c1", 4'd7);
    @(negedge clk);
    check_cmp("rst2_c2", 4'd11);
    @(negedge clk);
    check_cmp("rst2_c3", 4'd13);
    @(negedge clk);
    check_cmp("rst2_c4", 4'd14);
    @(negedge clk);
    check_cmp("rst2_c5", 4'd15);
    @(negedge clk);
    check_done("rst2", 1'b1, 1'b0, 4'd15);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
